impl_top_uart: RTL and testbench

- FPGA top level: 8N1 UART receiver on `uart_rxd`, clocked by a 50 MHz board clock.
- The last correctly framed byte is held in internal register `data` and driven onto the green LEDs and RGB LEDs.
- Receiver is an internal sub-instance `i_uart_rx`. It exposes localparams `SAMPLES_PER_BIT` and `SAMPLES_THRESHOLD`, which benches read hierarchically.

---
 rtl/impl_top_uart.sv | 185 ++++++++++++++++++
 tb/tb_impl_top_uart.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/impl_top_uart.sv
// 8N1 UART receiver top level: the last correctly framed byte is shown on the
// green LEDs (low nibble) and on bit 0 of the four RGB LEDs (high nibble).

module uart_rx #(
   parameter int unsigned CLK_PERIOD_NS = 20,
   parameter int unsigned BIT_PERIOD_NS = 3520
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       rx_valid
);
   timeunit 1ns;
   timeprecision 1ps;

   localparam int unsigned SAMPLES_PER_BIT   = BIT_PERIOD_NS / CLK_PERIOD_NS;
   localparam int unsigned SAMPLES_THRESHOLD = SAMPLES_PER_BIT / 2;
   localparam int unsigned CW                = $clog2(SAMPLES_PER_BIT + 1);
   localparam logic [CW-1:0] LAST_SAMPLE     = CW'(SAMPLES_PER_BIT - 1);
   localparam logic [CW-1:0] THRESH          = CW'(SAMPLES_THRESHOLD);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q;
   logic          rxs_prev_q;
   logic [1:0]    fill_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] ones_q, ones_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;

   logic          rxs;
   logic          armed;
   logic          win_end;
   logic [CW-1:0] ones_sum;
   logic          bit_val;

   assign rxs      = sync_q[1];
   // rxs_prev only holds a real line sample once three edges have passed since
   // reset, so a line that is already low at release is not seen as a start.
   assign armed    = (fill_q == 2'd3);
   assign win_end  = (cnt_q == LAST_SAMPLE);
   assign ones_sum = ones_q + CW'(rxs);
   assign bit_val  = (ones_sum > THRESH);
   assign rx_byte  = sh_q;

   // Synchroniser, edge-detect history and post-reset fill counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         rxs_prev_q <= 1'b1;
         fill_q     <= 2'd0;
      end else begin
         sync_q     <= {sync_q[0], rxd};
         rxs_prev_q <= rxs;
         if (fill_q != 2'd3) begin
            fill_q <= fill_q + 2'd1;
         end
      end
   end

   // Receiver state, window counters and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ones_q  <= '0;
         idx_q   <= 3'd0;
         sh_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ones_q  <= ones_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
      end
   end

   // Next state: majority vote over each bit window, LSB-first assembly.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ones_d   = ones_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      rx_valid = 1'b0;

      if (state_q == StIdle || win_end) begin
         cnt_d  = '0;
         ones_d = '0;
      end else begin
         cnt_d  = cnt_q + CW'(1);
         ones_d = ones_sum;
      end

      unique case (state_q)
         StIdle: begin
            if (armed && rxs_prev_q && !rxs) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (win_end) begin
               if (bit_val) begin
                  state_d = StIdle;
               end else begin
                  state_d = StData;
                  idx_d   = 3'd0;
               end
            end
         end
         StData: begin
            if (win_end) begin
               sh_d[idx_q] = bit_val;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (win_end) begin
               rx_valid = bit_val;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end
endmodule

module impl_top_uart #(
   parameter int unsigned CLK_PERIOD_NS = 20,
   parameter int unsigned BIT_PERIOD_NS = 3520
) (
   input  logic       clk,
   input  logic [3:0] sw,
   output logic [2:0] rgb0,
   output logic [2:0] rgb1,
   output logic [2:0] rgb2,
   output logic [2:0] rgb3,
   output logic [3:0] led,
   input  logic       uart_rxd
);
   timeunit 1ns;
   timeprecision 1ps;

   logic       rst_n;
   logic [7:0] data;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       unused_sw;

   assign rst_n     = sw[0];
   assign unused_sw = ^sw[3:1];

   uart_rx #(
      .CLK_PERIOD_NS(CLK_PERIOD_NS),
      .BIT_PERIOD_NS(BIT_PERIOD_NS)
   ) i_uart_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .rxd     (uart_rxd),
      .rx_byte (rx_byte),
      .rx_valid(rx_valid)
   );

   // Hold the last byte whose stop bit was sampled high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= 8'h00;
      end else if (rx_valid) begin
         data <= rx_byte;
      end
   end

   assign led  = data[3:0];
   assign rgb0 = {2'b00, data[4]};
   assign rgb1 = {2'b00, data[5]};
   assign rgb2 = {2'b00, data[6]};
   assign rgb3 = {2'b00, data[7]};
endmodule

// File: tb/tb_impl_top_uart.sv
// Scoreboard bench for impl_top_uart: the driver serialises frames and queues
// the byte each good frame should leave on the LEDs; the monitor checks it.

module tb_impl_top_uart;
   timeunit 1ns;
   timeprecision 1ps;

   localparam int BIT_NS = 3520;

   logic       clk = 1'b0;
   logic [3:0] sw;
   logic       uart_rxd;
   logic [2:0] rgb0, rgb1, rgb2, rgb3;
   logic [3:0] led;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_data;

   always #10 clk = ~clk;

   impl_top_uart dut (
      .clk     (clk),
      .sw      (sw),
      .rgb0    (rgb0),
      .rgb1    (rgb1),
      .rgb2    (rgb2),
      .rgb3    (rgb3),
      .led     (led),
      .uart_rxd(uart_rxd)
   );

   task automatic check_leds(input string name, input logic [7:0] exp);
      n_cmp++;
      if (led !== exp[3:0] || rgb0 !== {2'b00, exp[4]} || rgb1 !== {2'b00, exp[5]} ||
          rgb2 !== {2'b00, exp[6]} || rgb3 !== {2'b00, exp[7]}) begin
         n_bad++;
         $display("FAIL %s: led=%h rgb3..0=%b %b %b %b, required data=%h", name, led,
                  rgb3, rgb2, rgb1, rgb0, exp);
      end
   endtask

   // Serial frame: start, 8 data bits LSB first, stop level for stop_ns, idle gap.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_ns,
                             input int gap_ns);
      check_leds("pre_frame", model_data);
      if (stop_bit) exp_q.push_back(b);
      uart_rxd = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         #BIT_NS;
      end
      uart_rxd = stop_bit;
      check_leds("stop_start", model_data);
      #stop_ns;
      uart_rxd = 1'b1;
      #gap_ns;
      if (stop_bit) model_data = b;
   endtask

   // Monitor: whenever the receiver accepts a frame, check the LEDs one cycle later.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (dut.i_uart_rx.rx_valid === 1'b1) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_byte: led=%h rgb3..0=%b %b %b %b, required no update",
                        led, rgb3, rgb2, rgb1, rgb0);
            end else begin
               e = exp_q.pop_front();
               check_leds("rx_byte", e);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int spb;
      int thr;
      model_data = 8'h00;
      sw         = 4'b0000;
      uart_rxd   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_leds("reset", 8'h00);

      spb = dut.i_uart_rx.SAMPLES_PER_BIT;
      thr = dut.i_uart_rx.SAMPLES_THRESHOLD;
      n_cmp++;
      if (spb != 176) begin
         n_bad++;
         $display("FAIL samples_per_bit: got %0d, required 176", spb);
      end
      n_cmp++;
      if (thr != 88) begin
         n_bad++;
         $display("FAIL samples_threshold: got %0d, required 88", thr);
      end

      sw = 4'b0001;
      repeat (10) @(negedge clk);

      // First frame with a long stop bit.
      send_frame(8'hA5, 1'b1, 4020, 500);
      send_frame(8'h00, 1'b1, BIT_NS, 500);
      send_frame(8'hFF, 1'b1, BIT_NS, 500);

      // Random bytes, back-to-back with short idle gaps.
      for (int k = 0; k < 22; k++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1, BIT_NS, 500);
      end

      // Framing error leaves data alone, next good frame lands.
      send_frame(8'h3C, 1'b0, BIT_NS, 500);
      send_frame(8'h81, 1'b1, BIT_NS, 500);

      // Short low glitch is rejected as a start bit.
      uart_rxd = 1'b0;
      #40;
      uart_rxd = 1'b1;
      #(2 * BIT_NS);
      check_leds("glitch", model_data);
      send_frame(8'h7E, 1'b1, BIT_NS, 500);

      // Reset during bit 4 of 8'hFF aborts the frame and clears data.
      check_leds("pre_abort", model_data);
      uart_rxd = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 4; i++) begin
         uart_rxd = 1'b1;
         #BIT_NS;
      end
      uart_rxd = 1'b1;
      #1760;
      sw = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      check_leds("reset_mid_frame", 8'h00);
      model_data = 8'h00;
      sw = 4'b0001;
      #(2 * BIT_NS);
      check_leds("after_abort", 8'h00);
      send_frame(8'h12, 1'b1, BIT_NS, 500);
      check_leds("final", 8'h12);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_bytes: %0d outstanding, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
